// File: rtl/alu_pkg.sv
// Shared opcode constants, widths and the response record for the ALU arbiter.
package alu_pkg;

  localparam int ALU_W = 32;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR = 3'd2;
  localparam logic [OP_W-1:0] OP_SLT = 3'd3;
  localparam logic [OP_W-1:0] OP_CNE = 3'd4;
  localparam logic [OP_W-1:0] OP_MAX = OP_CNE;

  // Contents of the single-entry response register
  typedef struct packed {
    logic             id;
    logic [ALU_W-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;
    logic             err;
  } rsp_t;

  // True for opcodes the ALU defines
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit ALU: ADD, SUB, XOR, SLT (signed), CNE.
// Undefined opcodes produce a zero result with carry/overflow clear.
module ALU
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  command,
  input  logic [ALU_W-1:0] operandA,
  input  logic [ALU_W-1:0] operandB,
  output logic [ALU_W-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  logic [ALU_W:0] add_full;
  logic [ALU_W:0] sub_full;

  // SUB is A + ~B + 1, so carryout means "no borrow" (A >= B unsigned)
  assign add_full = {1'b0, operandA} + {1'b0, operandB};
  assign sub_full = {1'b0, operandA} + {1'b0, ~operandB} + {{ALU_W{1'b0}}, 1'b1};

  // Opcode decode and result/flag selection
  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (command)
      OP_ADD: begin
        result   = add_full[ALU_W-1:0];
        carryout = add_full[ALU_W];
        overflow = (operandA[ALU_W-1] == operandB[ALU_W-1]) &&
                   (add_full[ALU_W-1] != operandA[ALU_W-1]);
      end
      OP_SUB: begin
        result   = sub_full[ALU_W-1:0];
        carryout = sub_full[ALU_W];
        overflow = (operandA[ALU_W-1] != operandB[ALU_W-1]) &&
                   (sub_full[ALU_W-1] != operandA[ALU_W-1]);
      end
      OP_XOR: result = operandA ^ operandB;
      OP_SLT: result = {{(ALU_W-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      OP_CNE: result = {{(ALU_W-1){1'b0}}, (operandA != operandB)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with its pointer flop.
// The pointer names the requester that wins the next simultaneous contest
// and flips to the other requester after every grant.
module rr_arb2 #(
  parameter int PRIORITY_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_reg;
  logic ptr_next;

  // Grant selection and pointer update
  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr_reg;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    if (grant[0]) begin
      ptr_next = 1'b1;
    end else if (grant[1]) begin
      ptr_next = 1'b0;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= (PRIORITY_INIT != 0);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU with a
// single-entry response register.
// Optional build macro ALU_ARB_CMD_CHECK_EN: opcodes above OP_MAX are still
// accepted but answered with rsp_err=1, zero result and all flags clear.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int PRIORITY_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OP_W-1:0]  req0_command,
  input  logic [OP_W-1:0]  req1_command,
  input  logic [WIDTH-1:0] req0_operandA,
  input  logic [WIDTH-1:0] req0_operandB,
  input  logic [WIDTH-1:0] req1_operandA,
  input  logic [WIDTH-1:0] req1_operandB,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err
);

  logic             can_issue;
  logic [1:0]       grant;
  logic             accept;
  logic [OP_W-1:0]  alu_cmd;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             alu_zero;
  logic             alu_overflow;

  logic rsp_valid_reg;
  logic rsp_valid_next;
  rsp_t rsp_reg;
  rsp_t rsp_next;

  // Issue when the register is empty or is being drained this cycle;
  // nothing is granted while reset is asserted.
  assign can_issue = rst_n & (~rsp_valid_reg | rsp_ready);

  rr_arb2 #(.PRIORITY_INIT(PRIORITY_INIT)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (can_issue),
    .req    (req_valid),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Steer the granted requester into the shared ALU
  assign alu_cmd = grant[1] ? req1_command  : req0_command;
  assign alu_a   = grant[1] ? req1_operandA : req0_operandA;
  assign alu_b   = grant[1] ? req1_operandB : req0_operandB;

  ALU u_alu (
    .command  (alu_cmd),
    .operandA (alu_a),
    .operandB (alu_b),
    .result   (alu_result),
    .carryout (alu_carryout),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  // Response register next state: load on acceptance, empty on drain
  always_comb begin
    rsp_valid_next = rsp_valid_reg;
    rsp_next       = rsp_reg;
    if (accept) begin
      rsp_valid_next    = 1'b1;
      rsp_next.id       = grant[1];
      rsp_next.result   = alu_result;
      rsp_next.carryout = alu_carryout;
      rsp_next.zero     = alu_zero;
      rsp_next.overflow = alu_overflow;
      rsp_next.err      = 1'b0;
`ifdef ALU_ARB_CMD_CHECK_EN
      if (!op_legal(alu_cmd)) begin
        rsp_next.result   = '0;
        rsp_next.carryout = 1'b0;
        rsp_next.zero     = 1'b0;
        rsp_next.overflow = 1'b0;
        rsp_next.err      = 1'b1;
      end
`endif
    end else if (rsp_ready) begin
      rsp_valid_next = 1'b0;
    end
  end

  // Response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_reg       <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_reg       <= rsp_next;
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = rsp_reg.id;
  assign rsp_result   = rsp_reg.result;
  assign rsp_carryout = rsp_reg.carryout;
  assign rsp_zero     = rsp_reg.zero;
  assign rsp_overflow = rsp_reg.overflow;
  assign rsp_err      = rsp_reg.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps followed by random
// traffic, checked against a behavioural model of arbitration and the ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  cmd [2];
  logic [31:0] opa [2];
  logic [31:0] opb [2];
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carryout, rsp_zero, rsp_overflow, rsp_err;

  int tests = 0;
  int failed = 0;

  // model state
  bit          m_full;
  bit          m_ptr;
  bit          m_id;
  logic [31:0] m_res;
  bit          m_co, m_z, m_ov, m_err;
  int          grant_log[$];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .PRIORITY_INIT(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req0_command  (cmd[0]),
    .req1_command  (cmd[1]),
    .req0_operandA (opa[0]),
    .req0_operandB (opb[0]),
    .req1_operandA (opa[1]),
    .req1_operandB (opb[1]),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_carryout  (rsp_carryout),
    .rsp_zero      (rsp_zero),
    .rsp_overflow  (rsp_overflow),
    .rsp_err       (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from arithmetic definitions
  task automatic ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic co, output logic z,
                         output logic ov, output logic er);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 0; co = 0; ov = 0; er = 0;
    case (op)
      3'd0: begin
        r  = x + y;
        co = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
        s  = sx + sy;
        ov = (s > SMAX) || (s < SMIN);
      end
      3'd1: begin
        r  = x - y;
        co = (x >= y);
        s  = sx - sy;
        ov = (s > SMAX) || (s < SMIN);
      end
      3'd2: r = x ^ y;
      3'd3: r = (sx < sy) ? 32'd1 : 32'd0;
      3'd4: r = (x != y) ? 32'd1 : 32'd0;
      default: r = 0;
    endcase
    z = (r == 0);
`ifdef ALU_ARB_CMD_CHECK_EN
    if (op > 3'd4) begin
      r = 0; co = 0; z = 0; ov = 0; er = 1;
    end
`endif
  endtask

  task automatic m_reset();
    m_full = 0; m_ptr = 0; m_id = 0; m_res = 0;
    m_co = 0; m_z = 0; m_ov = 0; m_err = 0;
  endtask

  task automatic present(input int k, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    cmd[k] = c; opa[k] = a; opb[k] = b;
  endtask

  // One clock: check grant, advance model across the edge, check response.
  // Entered and left at posedge+1.
  task automatic cycle();
    logic [1:0]  g;
    logic [31:0] r;
    logic        co, z, ov, er;
    int          k;
    #1;
    g = 2'b00;
    if (rst_n && (!m_full || rsp_ready)) begin
      if (req_valid == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
      else g = req_valid;
    end
    chk("req_ready", req_ready, g);
    if (req_ready != 2'b00) grant_log.push_back(int'(req_ready[1]));
    @(posedge clk);
    k = -1;
    if (g != 2'b00) begin
      k = g[1] ? 1 : 0;
      ref_alu(cmd[k], opa[k], opb[k], r, co, z, ov, er);
      m_full = 1; m_id = k[0]; m_res = r;
      m_co = co; m_z = z; m_ov = ov; m_err = er;
      m_ptr = (k == 0);
    end else if (rsp_ready) begin
      m_full = 0;
    end
    #1;
    if (k >= 0) req_valid[k] = 1'b0;
    chk("rsp_valid", rsp_valid, m_full);
    if (m_full) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_carryout", rsp_carryout, m_co);
      chk("rsp_zero", rsp_zero, m_z);
      chk("rsp_overflow", rsp_overflow, m_ov);
      chk("rsp_err", rsp_err, m_err);
    end
  endtask

  initial begin
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    for (int k = 0; k < 2; k++) present(k, 3'd0, 32'd0, 32'd0);
    m_reset();

    // Reset values, with requests present
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_flags", {rsp_carryout, rsp_zero, rsp_overflow, rsp_err}, 4'b0000);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: SUB 20-20 on req0, XOR 5^3 on req1, both re-presented
    present(0, 3'd1, 32'd20, 32'd20);
    present(1, 3'd2, 32'd5, 32'd3);
    grant_log.delete();
    req_valid = 2'b11;
    cycle();
    chk("cont_first_result", rsp_result, 32'd0);
    chk("cont_first_zero", rsp_zero, 1'b1);
    req_valid = 2'b11;
    cycle();
    chk("cont_second_result", rsp_result, 32'd6);
    for (int i = 0; i < 2; i++) begin
      req_valid = 2'b11;
      cycle();
    end
    req_valid = 2'b00;
    cycle();
    for (int i = 0; i < 4; i++) chk("cont_grant_order", grant_log[i], i % 2);

    // ADD 20+20 from req0 alone
    present(0, 3'd0, 32'd20, 32'd20);
    req_valid = 2'b01;
    cycle();
    chk("add_result", rsp_result, 32'd40);
    chk("add_id", rsp_id, 1'b0);
    cycle();

    // Backpressure: fill, hold 3 cycles, then drain and refill together
    present(0, 3'd0, 32'h7FFF_FFFF, 32'd1);
    present(1, 3'd1, 32'd3, 32'd9);
    req_valid = 2'b11;
    cycle();
    rsp_ready = 1'b0;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    // SLT from req1: -1 < 1
    present(1, 3'd3, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b10;
    cycle();
    chk("slt_result", rsp_result, 32'd1);
    chk("slt_id", rsp_id, 1'b1);
    cycle();

    // Undefined opcode is still accepted
    present(0, 3'd6, 32'd123, 32'd45);
    req_valid = 2'b01;
    cycle();
`ifdef ALU_ARB_CMD_CHECK_EN
    chk("illegal_err", rsp_err, 1'b1);
`else
    chk("illegal_err", rsp_err, 1'b0);
`endif
    cycle();

    // Reset pulse while FULL and stalled
    present(0, 3'd0, 32'd1, 32'd2);
    req_valid = 2'b01;
    cycle();
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_rsp_result", rsp_result, 32'd0);
    chk("midrst_req_ready", req_ready, 2'b00);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    present(0, 3'd4, 32'd7, 32'd7);
    present(1, 3'd4, 32'd7, 32'd8);
    grant_log.delete();
    req_valid = 2'b11;
    cycle();
    chk("post_reset_ptr", grant_log[0], 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(3) != 0);
      for (int k = 0; k < 2; k++) begin
        if (!req_valid[k] && ($urandom_range(1) == 1)) begin
          logic [31:0] a, b;
          a = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
          b = ($urandom_range(5) == 0) ? a : $urandom;
          present(k, 3'($urandom_range(7)), a, b);
          req_valid[k] = 1'b1;
        end
      end
      cycle();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
